// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end. It takes the current PC from the PC register,
// fetches one instruction word at a time through a req/ack memory handshake,
// and queues fetched words in a small prefetch FIFO for the decode stage.
// It also steers the PC register: CTRLHalt = 0 makes the PC load NovoEndereco
// at the next edge, CTRLHalt = 1 makes it hold.
//
// Ports
//   CLK, Reset        clock; synchronous active-high reset
//   EnderecoAtual     current PC (input from the PC register)
//   NovoEndereco      next PC (output to the PC register)
//   CTRLHalt          1 = PC holds, 0 = PC loads NovoEndereco
//   BranchTaken       single-cycle redirect request from execute
//   BranchTarget      redirect address
//   ExtHalt           global stall, blocks new memory requests only
//   MemReq, MemAddr   instruction memory request and address
//   MemAck, MemData   memory response strobe and instruction word
//   InstrValid        FIFO head valid
//   Instrucao         FIFO head instruction word
//   InstrPC           address the head instruction was fetched from
//   InstrReady        decode accepts the head entry
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int DEPTH = 2,
    parameter int INC   = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] EnderecoAtual,
    output logic [31:0] NovoEndereco,
    output logic        CTRLHalt,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        ExtHalt,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemAck,
    input  logic [31:0] MemData,
    output logic        InstrValid,
    output logic [31:0] Instrucao,
    output logic [31:0] InstrPC,
    input  logic        InstrReady
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_reg;
    logic [31:0]      mem_addr_reg;
    logic             discard_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      instr_mem [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];

    logic push;
    logic pop;
    logic issue;

    // A response is kept only if it belongs to the current path: not marked
    // stale by an earlier redirect and not overtaken by a redirect this cycle.
    assign push  = (state_reg == ST_WAIT) && MemAck && !discard_reg && !BranchTaken;
    assign pop   = (count_reg != '0) && InstrReady;
    // A redirect in IDLE suppresses the request: EnderecoAtual still holds the
    // old path, the target is fetched once the PC has loaded it.
    assign issue = (state_reg == ST_IDLE) && !ExtHalt && !BranchTaken
                   && (count_reg < CNT_W'(DEPTH));

    // PC register control; a redirect overrides the sequential increment.
    always_comb begin
        CTRLHalt     = 1'b1;
        NovoEndereco = EnderecoAtual;
        if (!Reset) begin
            if (BranchTaken) begin
                CTRLHalt     = 1'b0;
                NovoEndereco = BranchTarget;
            end else if (push) begin
                CTRLHalt     = 1'b0;
                NovoEndereco = EnderecoAtual + 32'(INC);
            end
        end
    end

    // Request FSM: one outstanding request, never aborted once issued.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg    <= ST_IDLE;
            mem_addr_reg <= '0;
            discard_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        mem_addr_reg <= EnderecoAtual;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (MemAck) begin
                        state_reg   <= ST_IDLE;
                        discard_reg <= 1'b0;
                    end else if (BranchTaken) begin
                        // Let the handshake finish but throw its data away.
                        discard_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // FIFO bookkeeping; a redirect flushes everything, including a same-cycle pop.
    always_ff @(posedge CLK) begin
        if (Reset || BranchTaken) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage; contents need no reset because count gates the head.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= MemData;
            pc_mem[wr_ptr_reg]    <= mem_addr_reg;
        end
    end

    assign MemReq     = (state_reg == ST_WAIT);
    assign MemAddr    = mem_addr_reg;
    assign InstrValid = (count_reg != '0);
    assign Instrucao  = InstrValid ? instr_mem[rd_ptr_reg] : '0;
    assign InstrPC    = InstrValid ? pc_mem[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. The bench owns the PC register and the instruction
// memory. A transaction-level reference model (outstanding-request flag, a
// queue of fetched {pc, word} pairs, a stale-response flag) predicts every
// DUT output each cycle. Directed scenarios come first, then random traffic.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam int INC   = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] EnderecoAtual;
    logic [31:0] NovoEndereco;
    logic        CTRLHalt;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        ExtHalt;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemData;
    logic        InstrValid;
    logic [31:0] Instrucao;
    logic [31:0] InstrPC;
    logic        InstrReady;

    fetch_unit #(.DEPTH(DEPTH), .INC(INC)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .EnderecoAtual(EnderecoAtual),
        .NovoEndereco (NovoEndereco),
        .CTRLHalt     (CTRLHalt),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .ExtHalt      (ExtHalt),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemAck       (MemAck),
        .MemData      (MemData),
        .InstrValid   (InstrValid),
        .Instrucao    (Instrucao),
        .InstrPC      (InstrPC),
        .InstrReady   (InstrReady)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetched_t;

    // Reference model state
    fetched_t    m_q[$];
    bit          m_pending;
    logic [31:0] m_paddr;
    bit          m_stale;
    logic [31:0] pc;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] seen_novo;
    logic        seen_halt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model and the bench-side PC register past the edge.
    task automatic step(input bit rst, input bit br, input logic [31:0] tgt,
                        input bit exth, input bit ack, input logic [31:0] data,
                        input bit rdy);
        bit          exp_halt;
        logic [31:0] exp_next;
        bit          accept;
        bit          do_pop;
        int          qsize;
        @(negedge CLK);
        Reset        = rst;
        BranchTaken  = br;
        BranchTarget = tgt;
        ExtHalt      = exth;
        MemAck       = ack;
        MemData      = data;
        InstrReady   = rdy;
        #1;
        accept   = !rst && m_pending && ack && !m_stale && !br;
        exp_halt = 1'b1;
        exp_next = pc;
        if (!rst && br) begin
            exp_halt = 1'b0;
            exp_next = tgt;
        end else if (accept) begin
            exp_halt = 1'b0;
            exp_next = pc + 32'(INC);
        end
        qsize = m_q.size();
        check("ctrlhalt", {31'd0, CTRLHalt}, {31'd0, exp_halt});
        if (!exp_halt) check("novoendereco", NovoEndereco, exp_next);
        check("memreq", {31'd0, MemReq}, {31'd0, m_pending});
        check("memaddr", MemAddr, m_paddr);
        check("instrvalid", {31'd0, InstrValid}, {31'd0, qsize != 0});
        check("instrucao", Instrucao, (qsize != 0) ? m_q[0].instr : 32'd0);
        check("instrpc", InstrPC, (qsize != 0) ? m_q[0].pc : 32'd0);
        seen_novo = NovoEndereco;
        seen_halt = CTRLHalt;
        do_pop = !rst && (qsize != 0) && rdy;
        @(posedge CLK);
        #1;
        if (rst) begin
            m_q.delete();
            m_pending = 1'b0;
            m_paddr   = 32'd0;
            m_stale   = 1'b0;
        end else begin
            if (br) begin
                m_q.delete();
            end else begin
                if (do_pop) begin
                    $display("pop pc=%h instr=%h", m_q[0].pc, m_q[0].instr);
                    void'(m_q.pop_front());
                end
                if (accept) m_q.push_back('{pc: m_paddr, instr: data});
            end
            if (m_pending) begin
                if (ack) begin
                    m_pending = 1'b0;
                    m_stale   = 1'b0;
                end else if (br) begin
                    m_stale = 1'b1;
                end
            end else if (!exth && !br && qsize < DEPTH) begin
                m_pending = 1'b1;
                m_paddr   = pc;
            end
        end
        if (!exp_halt) pc = exp_next;
        EnderecoAtual = pc;
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        pc            = start_pc;
        EnderecoAtual = start_pc;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b1; BranchTaken = 1'b0; BranchTarget = '0; ExtHalt = 1'b0;
        MemAck = 1'b0; MemData = '0; InstrReady = 1'b0;
        m_pending = 1'b0; m_paddr = '0; m_stale = 1'b0;
        pc = '0; EnderecoAtual = '0;

        // Sequential fetch and backpressure
        do_reset(32'h0);
        check("reset_halt", {31'd0, CTRLHalt}, 32'd1);
        check("reset_valid", {31'd0, InstrValid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("seq_addr0", MemAddr, 32'h0);
        step(0, 0, 0, 0, 1, 32'hE3A00001, 0);
        check("seq_next0", seen_novo, 32'h4);
        step(0, 0, 0, 0, 0, 0, 0);
        check("seq_addr1", MemAddr, 32'h4);
        step(0, 0, 0, 0, 1, 32'hE3A01002, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        check("bp_noreq", {31'd0, MemReq}, 32'd0);
        check("bp_head", Instrucao, 32'hE3A00001);
        step(0, 0, 0, 0, 0, 0, 1);
        check("bp_head2", Instrucao, 32'hE3A01002);
        check("bp_headpc2", InstrPC, 32'h4);
        step(0, 0, 0, 0, 0, 0, 0);
        check("bp_refetch", MemAddr, 32'h8);

        // Branch while a request is outstanding
        do_reset(32'h10);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h100, 0, 0, 0, 0);
        check("br_flush", {31'd0, InstrValid}, 32'd0);
        step(0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        check("br_drop", {31'd0, InstrValid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("br_target", MemAddr, 32'h100);

        // Branch coincident with the ack
        step(0, 1, 32'h200, 0, 1, 32'h00001234, 0);
        check("brack_drop", {31'd0, InstrValid}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hCAFE0001, 0);
        check("brack_accept", Instrucao, 32'hCAFE0001);
        check("brack_pc", InstrPC, 32'h200);

        // ExtHalt while waiting
        do_reset(32'h40);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'h11112222, 0);
        check("exth_next", seen_novo, 32'h44);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0);
        check("exth_noreq", {31'd0, MemReq}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("exth_resume", MemAddr, 32'h44);

        // Wrap-around and reset during WAIT
        do_reset(32'hFFFFFFFC);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'h0BADF00D, 0);
        check("wrap_next", seen_novo, 32'h0);
        check("wrap_halt", {31'd0, seen_halt}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_memreq", {31'd0, MemReq}, 32'd0);
        check("rst_valid", {31'd0, InstrValid}, 32'd0);
        step(0, 0, 0, 1, 1, 32'h77777777, 0);
        check("rst_stray", {31'd0, InstrValid}, 32'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst, br, exth, ack, rdy;
            rst  = ($urandom_range(0, 199) == 0);
            br   = ($urandom_range(0, 15) == 0);
            exth = ($urandom_range(0, 5) == 0);
            ack  = m_pending ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            rdy  = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 99) == 0) pc = 32'hFFFFFFF8;
            EnderecoAtual = pc;
            step(rst, br, {$urandom} & 32'hFFFF_FFFC, exth, ack, $urandom, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
